jump_ctrl: RTL and testbench

//  Command side of the character jump interface: turns player button presses into one-cycle

---
 rtl/jump_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_jump_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jump_ctrl.sv
// Jump command controller: button edges -> jump pulses, landing score, timeout and game over.
// Optional JUMP_BUFFER_EN keeps one request made during a jump and issues it after landing.
module jump_ctrl #(
  parameter int LAND_TIMEOUT_MS = 100,
  parameter int FALL_MS         = 500,
  parameter int SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               module_en,
  input  logic               one_ms_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               platform_left,
  input  logic               platform_right,
  input  logic               landed,
  output logic               jump_left,
  output logic               jump_right,
  output logic               jump_fail,
  output logic               busy,
  output logic               timeout_err,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam int TMR_MAX = (LAND_TIMEOUT_MS > FALL_MS) ? LAND_TIMEOUT_MS : FALL_MS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]   LAND_LIM  = TMR_W'(LAND_TIMEOUT_MS);
  localparam logic [TMR_W-1:0]   FALL_LIM  = TMR_W'(FALL_MS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LAND = 2'd1,
    FALL      = 2'd2,
    OVER      = 2'd3
  } state_t;

  state_t           state_r;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_inc_s;
  logic             btn_left_q_r;
  logic             btn_right_q_r;
  logic             rise_left_s;
  logic             rise_right_s;
  logic             req_vld_s;
  logic             req_right_s;
  logic             req_plat_s;
`ifdef JUMP_BUFFER_EN
  logic             pend_vld_r;
  logic             pend_right_r;
  logic             pend_plat_r;
`endif

  assign rise_left_s  = btn_left & ~btn_left_q_r;
  assign rise_right_s = btn_right & ~btn_right_q_r;
  assign timer_inc_s  = timer_r + TMR_W'(1);

  // Select the request IDLE acts on: a buffered one has priority over a fresh edge
  always_comb begin
    req_vld_s   = 1'b0;
    req_right_s = 1'b0;
    req_plat_s  = 1'b0;
`ifdef JUMP_BUFFER_EN
    if (pend_vld_r) begin
      req_vld_s   = 1'b1;
      req_right_s = pend_right_r;
      req_plat_s  = pend_plat_r;
    end else if (rise_left_s ^ rise_right_s) begin
      req_vld_s   = 1'b1;
      req_right_s = rise_right_s;
      req_plat_s  = rise_right_s ? platform_right : platform_left;
    end else begin
      req_vld_s   = 1'b0;
    end
`else
    if (rise_left_s ^ rise_right_s) begin
      req_vld_s   = 1'b1;
      req_right_s = rise_right_s;
      req_plat_s  = rise_right_s ? platform_right : platform_left;
    end else begin
      req_vld_s   = 1'b0;
    end
`endif
  end

  // Controller FSM with registered command pulses, score and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      timer_r       <= {TMR_W{1'b0}};
      btn_left_q_r  <= 1'b0;
      btn_right_q_r <= 1'b0;
      jump_left     <= 1'b0;
      jump_right    <= 1'b0;
      jump_fail     <= 1'b0;
      game_over     <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      score         <= {SCORE_W{1'b0}};
`ifdef JUMP_BUFFER_EN
      pend_vld_r    <= 1'b0;
      pend_right_r  <= 1'b0;
      pend_plat_r   <= 1'b0;
`endif
    end else begin
      btn_left_q_r  <= btn_left;
      btn_right_q_r <= btn_right;
      jump_left     <= 1'b0;
      jump_right    <= 1'b0;
      jump_fail     <= 1'b0;
      game_over     <= 1'b0;
      if (!module_en) begin
        state_r <= IDLE;
        busy    <= 1'b0;
        timer_r <= {TMR_W{1'b0}};
`ifdef JUMP_BUFFER_EN
        pend_vld_r <= 1'b0;
`endif
        // Score and error are cleared once the controller sits in IDLE while disabled
        if (state_r == IDLE) begin
          score       <= {SCORE_W{1'b0}};
          timeout_err <= 1'b0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (req_vld_s) begin
              timer_r <= {TMR_W{1'b0}};
              busy    <= 1'b1;
`ifdef JUMP_BUFFER_EN
              pend_vld_r <= 1'b0;
`endif
              if (req_plat_s) begin
                jump_left  <= ~req_right_s;
                jump_right <= req_right_s;
                state_r    <= WAIT_LAND;
              end else begin
                jump_fail  <= 1'b1;
                state_r    <= FALL;
              end
            end
          end
          WAIT_LAND: begin
`ifdef JUMP_BUFFER_EN
            if (rise_left_s ^ rise_right_s) begin
              pend_vld_r   <= 1'b1;
              pend_right_r <= rise_right_s;
              pend_plat_r  <= rise_right_s ? platform_right : platform_left;
            end
`endif
            // landed takes priority over a coinciding timeout tick
            if (landed) begin
              if (score != SCORE_MAX) score <= score + SCORE_W'(1);
              state_r <= IDLE;
              busy    <= 1'b0;
              timer_r <= {TMR_W{1'b0}};
            end else if (one_ms_tick) begin
              if (timer_inc_s >= LAND_LIM) begin
                timeout_err <= 1'b1;
                state_r     <= IDLE;
                busy        <= 1'b0;
                timer_r     <= {TMR_W{1'b0}};
`ifdef JUMP_BUFFER_EN
                pend_vld_r  <= 1'b0;
`endif
              end else begin
                timer_r <= timer_inc_s;
              end
            end
          end
          FALL: begin
            if (one_ms_tick) begin
              if (timer_inc_s >= FALL_LIM) begin
                game_over <= 1'b1;
                state_r   <= OVER;
                timer_r   <= {TMR_W{1'b0}};
              end else begin
                timer_r <= timer_inc_s;
              end
            end
          end
          OVER: begin
            busy <= 1'b1;
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
            timer_r <= {TMR_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed-vector bench for jump_ctrl; expected values are hand-derived per scenario.
module tb_jump_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       module_en = 1'b0;
  logic       one_ms_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       platform_left = 1'b0;
  logic       platform_right = 1'b0;
  logic       landed = 1'b0;
  logic       jump_left;
  logic       jump_right;
  logic       jump_fail;
  logic       busy;
  logic       timeout_err;
  logic [7:0] score;
  logic       game_over;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_score = 0;

  jump_ctrl #(.LAND_TIMEOUT_MS(100), .FALL_MS(500), .SCORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .module_en(module_en), .one_ms_tick(one_ms_tick),
    .btn_left(btn_left), .btn_right(btn_right), .platform_left(platform_left),
    .platform_right(platform_right), .landed(landed), .jump_left(jump_left),
    .jump_right(jump_right), .jump_fail(jump_fail), .busy(busy),
    .timeout_err(timeout_err), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      one_ms_tick = 1'b1;
      step();
      one_ms_tick = 1'b0;
    end
  endtask

  // right jump onto an existing platform, landed right away
  task automatic jump_land_right();
    platform_right = 1'b1;
    btn_right = 1'b1;
    step();
    btn_right = 1'b0;
    landed = 1'b1;
    step();
    landed = 1'b0;
    step();
    if (exp_score < 255) exp_score++;
  endtask

  initial begin
    step();
    step();
    check_vec("reset_busy", busy, 0);
    check_vec("reset_score", score, 0);
    check_vec("reset_pulses", {jump_left, jump_right, jump_fail, game_over, timeout_err}, 0);
    rst_n = 1'b1;
    module_en = 1'b1;
    step();

    // right jump, land after 80 ticks
    platform_right = 1'b1;
    btn_right = 1'b1;
    step();
    check_vec("jr_pulse", jump_right, 1);
    check_vec("jr_busy", busy, 1);
    check_vec("jr_no_left", jump_left, 0);
    btn_right = 1'b0;
    step();
    check_vec("jr_one_cycle", jump_right, 0);
    ticks(80);
    check_vec("jr_wait_busy", busy, 1);
    landed = 1'b1;
    step();
    landed = 1'b0;
    check_vec("land_score", score, 1);
    check_vec("land_busy", busy, 0);

    // async reset during WAIT_LAND
    btn_right = 1'b1;
    step();
    btn_right = 1'b0;
    check_vec("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_vec("async_busy", busy, 0);
    check_vec("async_score", score, 0);
    step();
    rst_n = 1'b1;
    step();
    check_vec("post_rst_busy", busy, 0);

    // jump to missing platform, fall, game over, disable
    platform_left = 1'b0;
    btn_left = 1'b1;
    step();
    btn_left = 1'b0;
    check_vec("fail_pulse", jump_fail, 1);
    check_vec("fail_no_left", jump_left, 0);
    check_vec("fail_busy", busy, 1);
    ticks(499);
    check_vec("fall_499", game_over, 0);
    ticks(1);
    check_vec("fall_500", game_over, 1);
    step();
    check_vec("go_one_cycle", game_over, 0);
    check_vec("over_busy", busy, 1);
    landed = 1'b1;
    step();
    landed = 1'b0;
    check_vec("over_landed_ignored", score, 0);
    module_en = 1'b0;
    step();
    step();
    check_vec("over_exit_busy", busy, 0);
    check_vec("over_exit_score", score, 0);
    module_en = 1'b1;
    step();

    // landed coinciding with the 100th tick wins
    exp_score = 0;
    jump_land_right();
    check_vec("score_one", score, exp_score);
    btn_right = 1'b1;
    step();
    btn_right = 1'b0;
    ticks(99);
    check_vec("tmo_99_err", timeout_err, 0);
    landed = 1'b1;
    one_ms_tick = 1'b1;
    step();
    landed = 1'b0;
    one_ms_tick = 1'b0;
    exp_score++;
    check_vec("coincide_score", score, exp_score);
    check_vec("coincide_err", timeout_err, 0);

    // timeout after 100 ticks with no landing
    btn_right = 1'b1;
    step();
    btn_right = 1'b0;
    ticks(99);
    check_vec("tmo_99_busy", busy, 1);
    ticks(1);
    check_vec("tmo_err", timeout_err, 1);
    check_vec("tmo_busy", busy, 0);
    check_vec("tmo_score", score, exp_score);
    landed = 1'b1;
    step();
    landed = 1'b0;
    check_vec("idle_landed_ignored", score, exp_score);

    // both buttons in the same cycle
    platform_left = 1'b1;
    btn_left = 1'b1;
    btn_right = 1'b1;
    step();
    check_vec("both_pulses", {jump_left, jump_right, jump_fail}, 0);
    check_vec("both_busy", busy, 0);
    btn_left = 1'b0;
    btn_right = 1'b0;
    step();

    // saturate score
    for (int i = 0; i < 258; i++) jump_land_right();
    check_vec("score_sat", score, 255);
    check_vec("sat_err_sticky", timeout_err, 1);
    module_en = 1'b0;
    step();
    step();
    check_vec("dis_score", score, 0);
    check_vec("dis_err", timeout_err, 0);
    module_en = 1'b1;
    step();

    // edge during WAIT_LAND then landed
    platform_right = 1'b1;
    platform_left = 1'b1;
    btn_right = 1'b1;
    step();
    btn_right = 1'b0;
    step();
    btn_left = 1'b1;
    step();
    btn_left = 1'b0;
    check_vec("buf_no_early", jump_left, 0);
    ticks(5);
    landed = 1'b1;
    step();
    landed = 1'b0;
    check_vec("buf_land_score", score, 1);
    check_vec("buf_cycle1", jump_left, 0);
    step();
`ifdef JUMP_BUFFER_EN
    check_vec("buf_cycle2", jump_left, 1);
    check_vec("buf_busy", busy, 1);
`else
    check_vec("buf_cycle2", jump_left, 0);
    check_vec("buf_busy", busy, 0);
`endif
    step();
    check_vec("buf_one_cycle", jump_left, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
